// File: rtl/spi_master_if.sv
// spi_master_if: command handshake and serial lines of spi_master; err exists only with SPI_MASTER_SEQ_CHK_EN
interface spi_master_if;
   logic       start;
   logic [9:0] tx_word;
   logic       MISO;
   logic       SS_n;
   logic       MOSI;
   logic       busy;
   logic       done;
   logic [7:0] rd_data;
   logic       rd_valid;
`ifdef SPI_MASTER_SEQ_CHK_EN
   logic       err;
   modport master (input start, tx_word, MISO, output SS_n, MOSI, busy, done, rd_data, rd_valid, err);
   modport slave (output start, tx_word, MISO, input SS_n, MOSI, busy, done, rd_data, rd_valid, err);
`else
   modport master (input start, tx_word, MISO, output SS_n, MOSI, busy, done, rd_data, rd_valid);
   modport slave (output start, tx_word, MISO, input SS_n, MOSI, busy, done, rd_data, rd_valid);
`endif
endinterface

// File: rtl/spi_master.sv
// spi_master: 10-bit command/payload SPI master with read-data capture; SPI_MASTER_SEQ_CHK_EN adds read-sequence checking and err
module spi_master #(
   parameter int RD_GAP = 3
) (
   input logic clk,
   input logic rst_n,
   spi_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, SELECT, CMD, SHIFT, TAIL, WAIT, RECV, DONE} state_t;
   state_t state, state_nx;
   logic [9:0] word, word_nx;
   logic [3:0] cnt, cnt_nx;
   logic [6:0] sh;
   logic accept;
   logic rd_cmd;
`ifdef SPI_MASTER_SEQ_CHK_EN
   logic armed;
   logic err_nx;
`endif
   assign rd_cmd = word[9:8] == 2'b11;
   assign word_nx = accept ? bus.tx_word : word;
   assign bus.busy = state != IDLE;
   // next state, phase counter and start acceptance
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      accept = 1'b0;
`ifdef SPI_MASTER_SEQ_CHK_EN
      err_nx = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef SPI_MASTER_SEQ_CHK_EN
            err_nx = bus.start && bus.tx_word[9:8] == 2'b11 && !armed;
            accept = bus.start && !err_nx;
`else
            accept = bus.start;
`endif
            state_nx = accept ? SELECT : IDLE;
         end
         SELECT: state_nx = CMD;
         CMD: begin
            state_nx = SHIFT;
            cnt_nx = 4'd0;
         end
         SHIFT: begin
            cnt_nx = cnt + 4'd1;
            state_nx = cnt == 4'd9 ? TAIL : SHIFT;
         end
         TAIL: begin
            cnt_nx = 4'd0;
            state_nx = rd_cmd ? WAIT : DONE;
         end
         WAIT: begin
            cnt_nx = cnt == 4'(RD_GAP - 1) ? 4'd0 : cnt + 4'd1;
            state_nx = cnt == 4'(RD_GAP - 1) ? RECV : WAIT;
         end
         RECV: begin
            cnt_nx = cnt + 4'd1;
            state_nx = cnt == 4'd7 ? DONE : RECV;
         end
         DONE: state_nx = IDLE;
      endcase
   end
   // state, receive shifter and outputs registered from the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         word <= '0;
         cnt <= '0;
         sh <= '0;
         bus.SS_n <= 1'b1;
         bus.MOSI <= 1'b0;
         bus.done <= 1'b0;
         bus.rd_valid <= 1'b0;
         bus.rd_data <= '0;
      end else begin
         state <= state_nx;
         word <= word_nx;
         cnt <= cnt_nx;
         bus.SS_n <= state_nx == IDLE || state_nx == DONE;
         bus.MOSI <= state_nx == CMD ? word_nx[9] : state_nx == SHIFT && word_nx[4'd9 - cnt_nx];
         bus.done <= state_nx == DONE;
         bus.rd_valid <= state_nx == DONE && rd_cmd;
         if (state == RECV) sh <= {sh[5:0], bus.MISO};
         if (state == RECV && cnt == 4'd7) bus.rd_data <= {sh, bus.MISO};
      end
   end
`ifdef SPI_MASTER_SEQ_CHK_EN
   // remembers an accepted read-address until its read-data frame completes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         armed <= 1'b0;
         bus.err <= 1'b0;
      end else begin
         bus.err <= err_nx;
         armed <= (accept && bus.tx_word[9:8] == 2'b10) || (armed && !(state == DONE && rd_cmd));
      end
   end
`endif
endmodule
